sram_write_buffer: RTL and testbench
====================================

Name: sram_write_buffer

Overview:
Write-side front end for the external async SRAM controller (16-bit data, 18-bit word address, active-low strobes).
- Accepts 16-bit words with byte enables from a producer (video/capture logic) into a small FIFO.
- Generates sequential word addresses from a loadable start address.
- Presents one write request at a time to the SRAM controller over a valid/ack handshake; the controller drives CE/WE/UB/LB from oReqAddr/oReqData/oReqByteEn.

Parameters:
DATA_W, 16, data word width (matches SRAM data bus)
ADDR_W, 18, SRAM word address width
DEPTH_LOG2, 3, log2 of FIFO depth (default 8 entries)

Ports:
Clock  input  1  system clock, all logic on posedge
Reset  input  1  synchronous, active-low reset (Reset==0 resets on the next posedge)
iStartAddr  input  ADDR_W  address loaded into the address counter
iLoadAddr  input  1  load strobe for iStartAddr
iWrData  input  DATA_W  producer write data
iWrByteEn  input  2  byte enables, active-high: [1]=upper byte, [0]=lower byte
iWrValid  input  1  producer has a word
oWrReady  output  1  FIFO can accept a word
oReqValid  output  1  write request to the SRAM controller
oReqAddr  output  ADDR_W  request address
oReqData  output  DATA_W  request data
oReqByteEn  output  2  request byte enables (controller inverts to UB/LB)
iReqAck  input  1  one-cycle pulse from the controller: write completed
oCount  output  DEPTH_LOG2+1  FIFO occupancy, 0..2^DEPTH_LOG2
oEmpty  output  1  oCount==0
oFull  output  1  oCount==2^DEPTH_LOG2
oAddrWrap  output  1  one-cycle pulse when the address counter wraps to 0

Behaviour:
- Reset (Reset==0 at posedge):
  - FIFO flushed: pointers 0, oCount=0, oEmpty=1, oFull=0.
  - oReqValid=0, oReqAddr=0, oReqData=0, oReqByteEn=0, oAddrWrap=0, FSM=IDLE.
  - oWrReady is driven low while Reset==0.
- Push: on posedge with iWrValid && oWrReady, {iWrData, iWrByteEn} is written at the write pointer. oWrReady = !oFull (combinational from registered count).
  - No write-through when full: a push with oFull=1 is not accepted even if a pop occurs in the same cycle.
- Pop: occurs on the posedge where FSM is in REQ and iReqAck==1.
- Simultaneous push and pop (not full): oCount unchanged, both pointers advance.
- Pointers wrap modulo 2^DEPTH_LOG2.
- Address counter:
  - Loads iStartAddr on iLoadAddr, only when FSM==IDLE; iLoadAddr in REQ is ignored.
  - Increments by 1 on each accepted ack.
  - 2^ADDR_W-1 wraps to 0; oAddrWrap is high for the cycle after that ack.
  - Load and increment never coincide (load is IDLE-only, increment is REQ-only).
- FSM:
  - IDLE: oReqValid=0. If FIFO non-empty at posedge, go to REQ, registering oReqAddr=counter and oReqData/oReqByteEn=FIFO head.
  - REQ: oReqValid=1; oReqAddr/oReqData/oReqByteEn held stable until ack.
  - On iReqAck in REQ: pop, increment address.
    - If FIFO still has an entry after the pop (oCount>1, or a simultaneous push), stay in REQ and register the next head and address (back-to-back requests, no idle cycle).
    - Else go to IDLE.
- Latency: a word pushed into an empty buffer in IDLE gives oReqValid=1 two posedges after the push edge (push edge, then IDLE->REQ edge).
- iReqAck while oReqValid=0: ignored; no pop, no increment.
- Reset while in REQ: the request is dropped and buffered data is lost. The controller must abort on oReqValid falling.
- Byte enable 2'b00 is still issued as a request (controller performs a no-op cycle); no filtering here.

Test Plan:
- Reset with Reset=0 for 2 cycles, stimulus toggling -> after release: oReqValid=0, oCount=0, oEmpty=1, oWrReady=1, oReqAddr=0.
- Load iStartAddr=18'h00100 in IDLE, push 16'hA5A5/2'b11 -> oReqValid=1 two edges later with oReqAddr=18'h00100, oReqData=16'hA5A5; ack -> oReqValid=0, oCount=0, next request address 18'h00101.
- Push 8 words with no acks -> oFull=1, oCount=8, oWrReady=0; 9th iWrValid not accepted; then ack every cycle -> 8 back-to-back requests with consecutive addresses and in-order data, no idle cycles.
- Start address 18'h3FFFE, push 3 words, ack all -> addresses 3FFFE, 3FFFF, 00000; oAddrWrap pulses once, for the cycle after the 3FFFF ack.
- oCount=4, push and ack in the same cycle -> oCount stays 4. iLoadAddr during REQ -> address is not changed. Spurious iReqAck in IDLE -> no count or address change.
- Reset=0 asserted mid-REQ with 5 words buffered -> next cycle oReqValid=0, oCount=0. After release, a new push is issued at address 0.

Source files
------------

// File: rtl/sram_write_buffer.sv
// sram_write_buffer: write-side front end for the async SRAM controller.
// Buffers producer words (data + byte enables) in a small FIFO, tags each
// with a sequential word address and offers them one at a time to the
// controller over a valid/ack handshake.
module sram_write_buffer #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 18,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_W-1:0]     iStartAddr,
  input  logic                  iLoadAddr,
  input  logic [DATA_W-1:0]     iWrData,
  input  logic [1:0]            iWrByteEn,
  input  logic                  iWrValid,
  output logic                  oWrReady,
  output logic                  oReqValid,
  output logic [ADDR_W-1:0]     oReqAddr,
  output logic [DATA_W-1:0]     oReqData,
  output logic [1:0]            oReqByteEn,
  input  logic                  iReqAck,
  output logic [DEPTH_LOG2:0]   oCount,
  output logic                  oEmpty,
  output logic                  oFull,
  output logic                  oAddrWrap
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int ENTRY_W = DATA_W + 2;
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  // FIFO storage: each entry is {data, byte enables}
  logic [ENTRY_W-1:0]    mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_LOG2-1:0] wr_ptr_inc, rd_ptr_inc;
  logic [DEPTH_LOG2:0]   count_reg, count_next;
  state_t                state_reg, state_next;
  logic [ADDR_W-1:0]     addr_cnt_reg, addr_cnt_next, addr_inc;
  logic [ADDR_W-1:0]     req_addr_reg, req_addr_next;
  logic [ENTRY_W-1:0]    req_entry_reg, req_entry_next;
  logic                  wrap_reg, wrap_next;
  logic                  push, pop;
  logic [ENTRY_W-1:0]    head, head_after_pop;

  assign oFull      = (count_reg == CNT_FULL);
  assign oEmpty     = (count_reg == '0);
  assign oCount     = count_reg;
  // Ready is held low during reset so nothing is accepted into a flushing FIFO
  assign oWrReady   = Reset & ~oFull;
  assign oReqValid  = (state_reg == REQ);
  assign oReqAddr   = req_addr_reg;
  assign oReqData   = req_entry_reg[ENTRY_W-1:2];
  assign oReqByteEn = req_entry_reg[1:0];
  assign oAddrWrap  = wrap_reg;

  assign push       = iWrValid & oWrReady;
  assign pop        = (state_reg == REQ) & iReqAck;
  assign wr_ptr_inc = wr_ptr_reg + 1'b1;
  assign rd_ptr_inc = rd_ptr_reg + 1'b1;
  assign addr_inc   = addr_cnt_reg + 1'b1;
  assign head       = mem[rd_ptr_reg];
  // With one entry left the next head is the word being pushed this cycle,
  // which is not in the array yet, so forward it straight from the input.
  assign head_after_pop = (count_reg > CNT_ONE) ? mem[rd_ptr_inc] : {iWrData, iWrByteEn};

  // Occupancy update from accepted push and pop
  always_comb begin
    count_next = count_reg;
    unique case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Next state, address counter and registered request fields
  always_comb begin
    state_next     = state_reg;
    addr_cnt_next  = addr_cnt_reg;
    req_addr_next  = req_addr_reg;
    req_entry_next = req_entry_reg;
    wrap_next      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (iLoadAddr) addr_cnt_next = iStartAddr;
        if (count_reg != '0) begin
          state_next     = REQ;
          req_addr_next  = addr_cnt_reg;
          req_entry_next = head;
        end
      end
      REQ: begin
        if (iReqAck) begin
          addr_cnt_next = addr_inc;
          wrap_next     = (addr_cnt_reg == '1);
          if ((count_reg > CNT_ONE) || push) begin
            req_addr_next  = addr_inc;
            req_entry_next = head_after_pop;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FIFO array write; contents need no reset since pointers define validity
  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr_reg] <= {iWrData, iWrByteEn};
  end

  // State, pointer, counter and request registers with synchronous reset
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      addr_cnt_reg  <= '0;
      req_addr_reg  <= '0;
      req_entry_reg <= '0;
      wrap_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      addr_cnt_reg  <= addr_cnt_next;
      req_addr_reg  <= req_addr_next;
      req_entry_reg <= req_entry_next;
      wrap_reg      <= wrap_next;
      if (push) wr_ptr_reg <= wr_ptr_inc;
      if (pop)  rd_ptr_reg <= rd_ptr_inc;
    end
  end

endmodule

// File: tb/tb_sram_write_buffer.sv
// Self-checking bench for sram_write_buffer: a queue-based model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_sram_write_buffer;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 18;
  localparam int DEPTH_LOG2 = 3;
  localparam int DEPTH = 8;

  logic              Clock = 1'b0;
  logic              Reset;
  logic [ADDR_W-1:0] iStartAddr;
  logic              iLoadAddr;
  logic [DATA_W-1:0] iWrData;
  logic [1:0]        iWrByteEn;
  logic              iWrValid;
  logic              oWrReady;
  logic              oReqValid;
  logic [ADDR_W-1:0] oReqAddr;
  logic [DATA_W-1:0] oReqData;
  logic [1:0]        oReqByteEn;
  logic              iReqAck;
  logic [DEPTH_LOG2:0] oCount;
  logic              oEmpty;
  logic              oFull;
  logic              oAddrWrap;

  sram_write_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .Clock(Clock), .Reset(Reset), .iStartAddr(iStartAddr), .iLoadAddr(iLoadAddr),
    .iWrData(iWrData), .iWrByteEn(iWrByteEn), .iWrValid(iWrValid), .oWrReady(oWrReady),
    .oReqValid(oReqValid), .oReqAddr(oReqAddr), .oReqData(oReqData), .oReqByteEn(oReqByteEn),
    .iReqAck(iReqAck), .oCount(oCount), .oEmpty(oEmpty), .oFull(oFull), .oAddrWrap(oAddrWrap)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of pending words plus the current request
  logic [17:0] mq[$];
  bit          m_valid = 1'b0;
  logic [17:0] m_ctr, m_addr, m_entry;
  bit          m_wrap = 1'b0;
  bit          model_on = 1'b0;

  // Model update: one transaction step per rising edge
  always @(posedge Clock) begin
    bit          acc_push, acc_ack;
    logic [17:0] w, old_ctr;
    if (!Reset) begin
      mq.delete();
      m_valid  = 1'b0;
      m_ctr    = '0;
      m_addr   = '0;
      m_entry  = '0;
      m_wrap   = 1'b0;
      model_on = 1'b1;
    end else begin
      w        = {iWrData, iWrByteEn};
      acc_push = iWrValid && (mq.size() < DEPTH);
      acc_ack  = m_valid && iReqAck;
      old_ctr  = m_ctr;
      m_wrap   = 1'b0;
      if (acc_ack) begin
        void'(mq.pop_front());
        m_wrap = (old_ctr == 18'h3FFFF);
        m_ctr  = old_ctr + 18'd1;
        if (mq.size() > 0) begin
          m_entry = mq[0];
          m_addr  = m_ctr;
        end else if (acc_push) begin
          m_entry = w;
          m_addr  = m_ctr;
        end else begin
          m_valid = 1'b0;
        end
      end else if (!m_valid) begin
        if (iLoadAddr) m_ctr = iStartAddr;
        if (mq.size() > 0) begin
          m_valid = 1'b1;
          m_entry = mq[0];
          m_addr  = old_ctr;
        end
      end
      if (acc_push) mq.push_back(w);
    end
  end

  // Compare DUT against the model on every falling edge
  always @(negedge Clock) begin
    if (model_on) begin
      chk("req_valid", 32'(oReqValid), 32'(m_valid));
      chk("count", 32'(oCount), 32'(mq.size()));
      chk("empty", 32'(oEmpty), 32'(mq.size() == 0));
      chk("full", 32'(oFull), 32'(mq.size() == DEPTH));
      chk("wr_ready", 32'(oWrReady), 32'(Reset && (mq.size() < DEPTH)));
      chk("addr_wrap", 32'(oAddrWrap), 32'(m_wrap));
      if (m_valid) begin
        chk("req_addr", 32'(oReqAddr), 32'(m_addr));
        chk("req_data", 32'(oReqData), 32'(m_entry[17:2]));
        chk("req_be", 32'(oReqByteEn), 32'(m_entry[1:0]));
      end
    end
  end

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  logic [17:0] seen [3];
  int n_addr, n_wrap;

  initial begin
    // Reset for two edges with stimulus toggling
    Reset = 1'b0; iStartAddr = 18'h00155; iLoadAddr = 1'b1; iWrData = 16'h1234;
    iWrByteEn = 2'b11; iWrValid = 1'b1; iReqAck = 1'b1;
    cyc();
    iLoadAddr = 1'b0; iWrValid = 1'b0; iReqAck = 1'b0; iWrData = 16'h4321;
    cyc();
    Reset = 1'b1; iStartAddr = '0; iWrData = '0; iWrByteEn = '0;
    #1;
    chk("rst_valid", 32'(oReqValid), 32'd0);
    chk("rst_count", 32'(oCount), 32'd0);
    chk("rst_empty", 32'(oEmpty), 32'd1);
    chk("rst_ready", 32'(oWrReady), 32'd1);
    chk("rst_addr", 32'(oReqAddr), 32'd0);
    $display("reset released");

    // Load start address and push one word
    iLoadAddr = 1'b1; iStartAddr = 18'h00100; iWrValid = 1'b1;
    iWrData = 16'hA5A5; iWrByteEn = 2'b11;
    cyc();
    iLoadAddr = 1'b0; iWrValid = 1'b0;
    chk("lat_one_edge", 32'(oReqValid), 32'd0);
    cyc();
    chk("lat_two_edges", 32'(oReqValid), 32'd1);
    chk("first_addr", 32'(oReqAddr), 32'h00100);
    chk("first_data", 32'(oReqData), 32'hA5A5);
    iReqAck = 1'b1;
    cyc();
    iReqAck = 1'b0;
    chk("after_ack_valid", 32'(oReqValid), 32'd0);
    chk("after_ack_count", 32'(oCount), 32'd0);
    iWrValid = 1'b1; iWrData = 16'h0B0B; iWrByteEn = 2'b01;
    cyc();
    iWrValid = 1'b0;
    cyc();
    chk("second_addr", 32'(oReqAddr), 32'h00101);
    chk("second_be", 32'(oReqByteEn), 32'd1);
    iReqAck = 1'b1;
    cyc();
    iReqAck = 1'b0;
    $display("single word transaction at 0x100/0x101 done");

    // Fill to full with no acks, then drain back-to-back
    for (int i = 0; i < DEPTH; i++) begin
      iWrValid = 1'b1; iWrData = 16'hC000 + 16'(i); iWrByteEn = 2'(i);
      cyc();
    end
    iWrValid = 1'b0;
    chk("fill_full", 32'(oFull), 32'd1);
    chk("fill_count", 32'(oCount), 32'd8);
    chk("fill_ready", 32'(oWrReady), 32'd0);
    iWrValid = 1'b1; iWrData = 16'hDEAD;
    cyc();
    iWrValid = 1'b0;
    chk("ninth_rejected", 32'(oCount), 32'd8);
    iReqAck = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("b2b_valid", 32'(oReqValid), 32'd1);
      chk("b2b_addr", 32'(oReqAddr), 32'h00102 + 32'(i));
      chk("b2b_data", 32'(oReqData), 32'hC000 + 32'(i));
      cyc();
    end
    iReqAck = 1'b0;
    chk("drain_valid", 32'(oReqValid), 32'd0);
    chk("drain_count", 32'(oCount), 32'd0);
    $display("fill/drain of 8 words done");

    // Address wrap at the top of the address space
    iLoadAddr = 1'b1; iStartAddr = 18'h3FFFE;
    cyc();
    iLoadAddr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iWrValid = 1'b1; iWrData = 16'h7700 + 16'(i); iWrByteEn = 2'b10;
      cyc();
    end
    iWrValid = 1'b0;
    n_addr = 0; n_wrap = 0;
    iReqAck = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (oReqValid) begin
        if (n_addr < 3) seen[n_addr] = oReqAddr;
        n_addr++;
      end
      cyc();
      if (oAddrWrap) begin
        n_wrap++;
        chk("wrap_after_second_ack", 32'(n_addr), 32'd2);
      end
    end
    iReqAck = 1'b0;
    chk("wrap_req_cnt", 32'(n_addr), 32'd3);
    chk("wrap_addr0", 32'(seen[0]), 32'h3FFFE);
    chk("wrap_addr1", 32'(seen[1]), 32'h3FFFF);
    chk("wrap_addr2", 32'(seen[2]), 32'h00000);
    chk("wrap_pulses", 32'(n_wrap), 32'd1);
    $display("address wrap sequence done");

    // Simultaneous push and ack, load in REQ, spurious ack in IDLE
    for (int i = 0; i < 4; i++) begin
      iWrValid = 1'b1; iWrData = 16'h5500 + 16'(i); iWrByteEn = 2'b11;
      cyc();
    end
    iWrValid = 1'b0;
    chk("four_count", 32'(oCount), 32'd4);
    chk("four_addr", 32'(oReqAddr), 32'h00001);
    iWrValid = 1'b1; iWrData = 16'h5504; iReqAck = 1'b1;
    cyc();
    iWrValid = 1'b0; iReqAck = 1'b0;
    chk("pushpop_count", 32'(oCount), 32'd4);
    chk("pushpop_addr", 32'(oReqAddr), 32'h00002);
    chk("pushpop_data", 32'(oReqData), 32'h5501);
    iLoadAddr = 1'b1; iStartAddr = 18'h12345;
    cyc();
    iLoadAddr = 1'b0;
    chk("load_in_req_ignored", 32'(oReqAddr), 32'h00002);
    iReqAck = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain4_addr", 32'(oReqAddr), 32'h00002 + 32'(i));
      chk("drain4_data", 32'(oReqData), 32'h5501 + 32'(i));
      cyc();
    end
    chk("drain4_valid", 32'(oReqValid), 32'd0);
    cyc();
    cyc();
    iReqAck = 1'b0;
    chk("spurious_count", 32'(oCount), 32'd0);
    chk("spurious_valid", 32'(oReqValid), 32'd0);
    iWrValid = 1'b1; iWrData = 16'h6666; iWrByteEn = 2'b00;
    cyc();
    iWrValid = 1'b0;
    cyc();
    chk("after_spurious_addr", 32'(oReqAddr), 32'h00006);
    chk("be00_issued", 32'(oReqValid), 32'd1);
    iReqAck = 1'b1;
    cyc();
    iReqAck = 1'b0;
    $display("push+ack, load-in-REQ and spurious-ack cases done");

    // Reset in the middle of a request with five words buffered
    for (int i = 0; i < 5; i++) begin
      iWrValid = 1'b1; iWrData = 16'h9900 + 16'(i); iWrByteEn = 2'b11;
      cyc();
    end
    iWrValid = 1'b0;
    chk("pre_rst_count", 32'(oCount), 32'd5);
    chk("pre_rst_valid", 32'(oReqValid), 32'd1);
    Reset = 1'b0;
    cyc();
    chk("mid_rst_valid", 32'(oReqValid), 32'd0);
    chk("mid_rst_count", 32'(oCount), 32'd0);
    chk("mid_rst_ready", 32'(oWrReady), 32'd0);
    Reset = 1'b1;
    #1;
    chk("post_rst_ready", 32'(oWrReady), 32'd1);
    iWrValid = 1'b1; iWrData = 16'hF00D; iWrByteEn = 2'b01;
    cyc();
    iWrValid = 1'b0;
    cyc();
    chk("post_rst_valid", 32'(oReqValid), 32'd1);
    chk("post_rst_addr", 32'(oReqAddr), 32'h00000);
    chk("post_rst_data", 32'(oReqData), 32'hF00D);
    iReqAck = 1'b1;
    cyc();
    iReqAck = 1'b0;
    cyc();
    $display("mid-request reset recovery done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
